// File: rtl/uart16550_pkg.sv
// Shared constants for the UART16550 AXI-Lite data path FIFOs.
//   DWIDTH   data width in bits
//   DEPTH    FIFO depth (power of 2)
//   AWIDTH   pointer width, log2(DEPTH)
//   CAP_FIFO capacity in FIFO mode
//   CAP_CHAR capacity in 16550 character mode (single holding register)
package uart16550_pkg;

  localparam int DWIDTH = 8;
  localparam int DEPTH  = 16;
  localparam int AWIDTH = 4;

  typedef logic [AWIDTH:0]   count_t;
  typedef logic [AWIDTH-1:0] ptr_t;
  typedef logic [DWIDTH-1:0] data_t;

  localparam count_t CAP_FIFO = count_t'(DEPTH);
  localparam count_t CAP_CHAR = count_t'(1);

endpackage

// File: rtl/uart16550_axil_fifo.sv
// First-word-fall-through FIFO with sticky overrun detection, used for the
// TX and RX data paths of the UART16550. In character mode the usable
// capacity drops to a single entry; any change of mode flushes the FIFO.
//
// Ports:
//   clk         clock, rising edge
//   reset_n     asynchronous reset, active HIGH despite the name
//   regmode     1 = character mode (capacity 1), 0 = FIFO mode (capacity 16)
//   idata       write data
//   write       push request
//   odata       head-of-queue data, combinational from storage
//   read        pop request
//   elems       current occupancy 0..16
//   empty       elems == 0
//   full        elems == capacity
//   oeflag      sticky overrun flag
//   clear_flag  synchronous clear of oeflag (an overrun on the same edge wins)
module uart16550_axil_fifo
  import uart16550_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              regmode,
  input  logic [DWIDTH-1:0] idata,
  input  logic              write,
  output logic [DWIDTH-1:0] odata,
  input  logic              read,
  output logic [AWIDTH:0]   elems,
  output logic              empty,
  output logic              full,
  output logic              oeflag,
  input  logic              clear_flag
);

  data_t  mem [DEPTH];
  ptr_t   rd_ptr;
  ptr_t   wr_ptr;
  count_t count;
  logic   regmode_q;

  count_t cap;
  logic   is_full;
  logic   is_empty;
  logic   do_pop;
  logic   do_push;
  logic   overrun;
  logic   mode_chg;

  // Capacity follows the registered mode so full/empty never depend
  // combinationally on an input pin.
  always_comb begin
    cap      = regmode_q ? CAP_CHAR : CAP_FIFO;
    is_full  = (count == cap);
    is_empty = (count == '0);
    mode_chg = (regmode != regmode_q);
    do_pop   = read && !is_empty;
    // A pop on the same edge frees a slot, so a write to a full FIFO is
    // accepted when paired with a read.
    do_push  = write && (!is_full || do_pop);
    overrun  = write && is_full && !do_pop;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push && !mode_chg) begin
      mem[wr_ptr] <= idata;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      oeflag    <= 1'b0;
      regmode_q <= 1'b0;
    end else begin
      regmode_q <= regmode;
      if (mode_chg) begin
        // Flush on any mode change; queued traffic on this edge is dropped.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
        if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
        if (do_push && !do_pop)      count <= count + count_t'(1);
        else if (do_pop && !do_push) count <= count - count_t'(1);
      end
      if (overrun && !mode_chg) oeflag <= 1'b1;
      else if (clear_flag)      oeflag <= 1'b0;
    end
  end

  assign odata = mem[rd_ptr];
  assign elems = count;
  assign empty = is_empty;
  assign full  = is_full;

endmodule

// File: tb/tb_uart16550_axil_fifo.sv
// Self-checking bench for uart16550_axil_fifo. A queue-based reference model
// tracks contents, capacity and the overrun flag; directed scenarios are
// followed by randomized traffic in both modes.
module tb_uart16550_axil_fifo;

  logic       clk;
  logic       reset_n;
  logic       regmode;
  logic [7:0] idata;
  logic       write;
  logic [7:0] odata;
  logic       read;
  logic [4:0] elems;
  logic       empty;
  logic       full;
  logic       oeflag;
  logic       clear_flag;

  int tests  = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         moe;
  bit         mmode_q;

  uart16550_axil_fifo dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .regmode    (regmode),
    .idata      (idata),
    .write      (write),
    .odata      (odata),
    .read       (read),
    .elems      (elems),
    .empty      (empty),
    .full       (full),
    .oeflag     (oeflag),
    .clear_flag (clear_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behaviour of one clock edge, from the FIFO rules.
  task automatic model_edge(input bit w, input bit r, input bit c, input logic [7:0] d);
    int  cap;
    bit  was_full;
    bit  p;
    if (regmode !== mmode_q) begin
      mq.delete();
      mmode_q = regmode;
      if (c) moe = 1'b0;
      return;
    end
    cap      = mmode_q ? 1 : 16;
    was_full = (mq.size() == cap);
    p        = r && (mq.size() > 0);
    if (w && was_full && !p) moe = 1'b1;
    else if (c)              moe = 1'b0;
    if (p) void'(mq.pop_front());
    if (w && (!was_full || p)) mq.push_back(d);
  endtask

  task automatic cyc(input bit w, input bit r, input bit c, input logic [7:0] d);
    write      = w;
    read       = r;
    clear_flag = c;
    idata      = d;
    @(posedge clk);
    model_edge(w, r, c, d);
    #1;
    write      = 1'b0;
    read       = 1'b0;
    clear_flag = 1'b0;
  endtask

  task automatic do_reset();
    regmode    = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    clear_flag = 1'b0;
    idata      = 8'h00;
    reset_n    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    mq.delete();
    moe     = 1'b0;
    mmode_q = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (elems !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || oeflag !== 1'b0) begin
      errors++;
      $display("FAIL reset: elems=%0d empty=%b full=%b oeflag=%b, want 0/1/0/0",
               elems, empty, full, oeflag);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, 8'(i));
      cyc(0, 0, 0, 8'h00);
    end
    tests++;
    if (elems !== 5'd16 || full !== 1'b1 || empty !== 1'b0 || odata !== 8'h00) begin
      errors++;
      $display("FAIL fill: elems=%0d full=%b empty=%b odata=%h, want 16/1/0/00",
               elems, full, empty, odata);
    end
  endtask

  task automatic test_overrun();
    cyc(1, 0, 0, 8'hFF);
    tests++;
    if (oeflag !== 1'b1 || elems !== 5'd16 || odata !== 8'h00) begin
      errors++;
      $display("FAIL overrun: oeflag=%b elems=%0d odata=%h, want 1/16/00", oeflag, elems, odata);
    end
    cyc(0, 0, 1, 8'h00);
    tests++;
    if (oeflag !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: oeflag=%b, want 0", oeflag);
    end
  endtask

  task automatic test_set_wins();
    cyc(1, 0, 1, 8'hFF);
    tests++;
    if (oeflag !== 1'b1 || elems !== 5'd16) begin
      errors++;
      $display("FAIL set_wins: oeflag=%b elems=%0d, want 1/16", oeflag, elems);
    end
    cyc(0, 0, 1, 8'h00);
    tests++;
    if (oeflag !== 1'b0) begin
      errors++;
      $display("FAIL set_wins_clear: oeflag=%b, want 0", oeflag);
    end
  endtask

  task automatic test_back_to_back();
    tests++;
    if (odata !== 8'h00) begin
      errors++;
      $display("FAIL pop_data: odata=%h, want 00", odata);
    end
    cyc(0, 1, 0, 8'h00);
    tests++;
    if (elems !== 5'd15) begin
      errors++;
      $display("FAIL pop_elems: elems=%0d, want 15", elems);
    end
    for (int k = 0; k < 100; k++) begin
      tests++;
      if (odata !== 8'(k + 1)) begin
        errors++;
        $display("FAIL b2b_data[%0d]: odata=%h, want %h", k, odata, 8'(k + 1));
      end
      cyc(1, 1, 0, 8'(k + 16));
      tests++;
      if (oeflag !== 1'b0 || elems !== 5'd15) begin
        errors++;
        $display("FAIL b2b_state[%0d]: oeflag=%b elems=%0d, want 0/15", k, oeflag, elems);
      end
    end
    // Simultaneous write and read while full: both happen, no overrun.
    cyc(1, 0, 0, 8'h77);
    tests++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL refill: full=%b, want 1", full);
    end
    cyc(1, 1, 0, 8'h88);
    tests++;
    if (oeflag !== 1'b0 || elems !== 5'd16 || odata !== 8'd102) begin
      errors++;
      $display("FAIL full_rw: oeflag=%b elems=%0d odata=%h, want 0/16/66", oeflag, elems, odata);
    end
  endtask

  task automatic test_char_mode();
    regmode = 1'b1;
    cyc(0, 0, 0, 8'h00);
    tests++;
    if (elems !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL char_flush: elems=%0d empty=%b, want 0/1", elems, empty);
    end
    cyc(1, 0, 0, 8'hA5);
    tests++;
    if (full !== 1'b1 || elems !== 5'd1 || odata !== 8'hA5) begin
      errors++;
      $display("FAIL char_push: full=%b elems=%0d odata=%h, want 1/1/a5", full, elems, odata);
    end
    cyc(1, 0, 0, 8'h5A);
    tests++;
    if (oeflag !== 1'b1 || elems !== 5'd1 || odata !== 8'hA5) begin
      errors++;
      $display("FAIL char_overrun: oeflag=%b elems=%0d odata=%h, want 1/1/a5", oeflag, elems, odata);
    end
    tests++;
    if (odata !== 8'hA5) begin
      errors++;
      $display("FAIL char_pop_data: odata=%h, want a5", odata);
    end
    cyc(0, 1, 0, 8'h00);
    tests++;
    if (empty !== 1'b1 || elems !== 5'd0) begin
      errors++;
      $display("FAIL char_pop: empty=%b elems=%0d, want 1/0", empty, elems);
    end
    cyc(1, 0, 0, 8'h3C);
    regmode = 1'b0;
    cyc(0, 0, 0, 8'h00);
    tests++;
    if (elems !== 5'd0 || empty !== 1'b1 || oeflag !== 1'b1) begin
      errors++;
      $display("FAIL mode_toggle: elems=%0d empty=%b oeflag=%b, want 0/1/1", elems, empty, oeflag);
    end
    cyc(0, 0, 1, 8'h00);
  endtask

  task automatic test_random();
    for (int m = 0; m < 2; m++) begin
      regmode = (m == 1);
      cyc(0, 0, 0, 8'h00);
      for (int n = 0; n < 400; n++) begin
        bit         w, r, c;
        int         wp, rp;
        logic [7:0] d;
        wp = (n % 100 < 50) ? 75 : 30;
        rp = (n % 100 < 50) ? 30 : 75;
        w  = ($urandom_range(0, 99) < wp);
        r  = ($urandom_range(0, 99) < rp);
        c  = ($urandom_range(0, 99) < 6);
        d  = 8'($urandom);
        if (mq.size() > 0) begin
          tests++;
          if (odata !== mq[0]) begin
            errors++;
            $display("FAIL rand_data[m%0d n%0d]: odata=%h, want %h", m, n, odata, mq[0]);
          end
        end
        cyc(w, r, c, d);
        tests++;
        if (elems !== 5'(mq.size()) || empty !== (mq.size() == 0) ||
            full !== (mq.size() == (m == 1 ? 1 : 16)) || oeflag !== moe) begin
          errors++;
          $display("FAIL rand_state[m%0d n%0d]: elems=%0d empty=%b full=%b oeflag=%b, want %0d/%b/%b/%b",
                   m, n, elems, empty, full, oeflag, mq.size(), mq.size() == 0,
                   mq.size() == (m == 1 ? 1 : 16), moe);
        end
      end
    end
    regmode = 1'b0;
    cyc(0, 0, 0, 8'h00);
  endtask

  initial begin
    reset_n = 1'b1;
    test_reset();
    test_fill();
    test_overrun();
    test_set_wins();
    test_back_to_back();
    test_char_mode();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
